// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier controller wrapped around the shared bus-wide ALU adder.
// Produces a 2*bus signed or unsigned product with fixed per-mode latency.
module alu_mul_sequencer #(
  parameter int unsigned bus = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [bus-1:0]     op_a,
  input  logic [bus-1:0]     op_b,
  output logic               busy,
  output logic               done,
  output logic [2*bus-1:0]   product,
  output logic [bus-1:0]     alu_a,
  output logic [bus-1:0]     alu_b,
  output logic               alu_cin,
  output logic               alu_c2,
  input  logic [bus-1:0]     alu_sout,
  input  logic               alu_cout
);

  localparam int unsigned CW  = $clog2(bus) + 1;
  localparam int unsigned MSB = bus - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_MUL, S_NEG_LO, S_NEG_HI, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [bus-1:0]     mcand_q, mcand_d;
  logic [bus-1:0]     acc_hi_q, acc_hi_d;
  logic [bus-1:0]     acc_lo_q, acc_lo_d;
  logic               neg_res_q, neg_res_d;
  logic               sgn_q, sgn_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*bus-1:0]   product_q, product_d;
  logic [bus-1:0]     alu_a_q, alu_a_d;
  logic [bus-1:0]     alu_b_q, alu_b_d;
  logic               alu_cin_q, alu_cin_d;
  logic               alu_c2_q, alu_c2_d;

  // Datapath and state sequencing; ALU results are consumed in the cycle they are driven.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    neg_res_d = neg_res_q;
    sgn_d     = sgn_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    product_d = product_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d   = op_a;
          acc_lo_d  = op_b;
          acc_hi_d  = '0;
          cnt_d     = '0;
          carry_d   = 1'b0;
          sgn_d     = signed_mode;
          neg_res_d = signed_mode & (op_a[MSB] ^ op_b[MSB]);
          state_d   = signed_mode ? S_NEG_A : S_MUL;
        end
      end
      S_NEG_A: begin
        if (mcand_q[MSB]) mcand_d = alu_sout;
        state_d = S_NEG_B;
      end
      S_NEG_B: begin
        if (acc_lo_q[MSB]) acc_lo_d = alu_sout;
        state_d = S_MUL;
      end
      S_MUL: begin
        if (acc_lo_q[0]) begin
          {acc_hi_d, acc_lo_d} = {alu_cout, alu_sout, acc_lo_q[bus-1:1]};
        end else begin
          {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[bus-1:1]};
        end
        carry_d = 1'b0;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(bus - 1)) state_d = sgn_q ? S_NEG_LO : S_DONE;
      end
      S_NEG_LO: begin
        if (neg_res_q) begin
          acc_lo_d = alu_sout;
          carry_d  = alu_cout;
        end
        state_d = S_NEG_HI;
      end
      S_NEG_HI: begin
        if (neg_res_q) acc_hi_d = alu_sout;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE && state_q != S_DONE) begin
      product_d = {acc_hi_d, acc_lo_d};
      done_d    = 1'b1;
    end
    busy_d = (state_d != S_IDLE);
  end

  // ALU drive for the upcoming state, built from next-cycle register values.
  always_comb begin
    alu_a_d   = '0;
    alu_b_d   = '0;
    alu_cin_d = 1'b0;
    alu_c2_d  = 1'b0;
    case (state_d)
      S_NEG_A:  begin alu_b_d = mcand_d;  alu_c2_d = 1'b1; alu_cin_d = 1'b1; end
      S_NEG_B:  begin alu_b_d = acc_lo_d; alu_c2_d = 1'b1; alu_cin_d = 1'b1; end
      S_MUL:    begin alu_a_d = acc_hi_d; alu_b_d = mcand_d; end
      S_NEG_LO: begin alu_b_d = acc_lo_d; alu_c2_d = 1'b1; alu_cin_d = 1'b1; end
      S_NEG_HI: begin alu_b_d = acc_hi_d; alu_c2_d = 1'b1; alu_cin_d = carry_d; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      neg_res_q <= 1'b0;
      sgn_q     <= 1'b0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_cin_q <= 1'b0;
      alu_c2_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      neg_res_q <= neg_res_d;
      sgn_q     <= sgn_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_cin_q <= alu_cin_d;
      alu_c2_q  <= alu_c2_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_cin = alu_cin_q;
  assign alu_c2  = alu_c2_q;

endmodule
